// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
// Requester IDs double as arbiter grant bit positions.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_W  = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic REQ_E = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin arbiter; a tie goes to the side not granted last.
// grant[REQ_E] / grant[REQ_D] are one-hot, all zero when disabled.
module aes_rr_arbiter
  import aes_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (1'b1)
        (req == 2'b11):
          grant = (lastGrant == REQ_D) ? 2'b01 : 2'b10;
        default:
          grant = req;
      endcase
    end
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Round sequencer sharing one AES round datapath between an encrypt
// and a decrypt requester; owns the state register and round counter.
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int W  = AES_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reqE,
  input  logic [W-1:0] msgE,
  input  logic         reqD,
  input  logic [W-1:0] msgD,
  output logic         ackE,
  output logic         ackD,
  output logic [W-1:0] dpStateIn,
  output logic         dpMode,
  output logic [3:0]   dpRound,
  output logic         dpFirst,
  output logic         dpLast,
  input  logic [W-1:0] dpResult,
  output logic [W-1:0] dataOut,
  output logic         doneE,
  output logic         doneD,
  output logic         busy
);

  localparam logic [3:0] NR4 = 4'(NR);

  state_e       fsm_q;
  logic [3:0]   r_q;
  logic [W-1:0] state_q;
  logic [W-1:0] dout_q;
  logic         mode_q;
  logic         owner_q;
  logic         last_q;
  logic         ackE_q, ackD_q;
  logic         doneE_q, doneD_q;
  logic         busy_q;
  logic         first_q;
  logic         lastr_q;
  logic [3:0]   round_q;

  logic [1:0]   grant;
  logic         gsel;

  aes_rr_arbiter u_arb (
    .req       ({reqD, reqE}),
    .lastGrant (last_q),
    .enable    (fsm_q == S_IDLE),
    .grant     (grant)
  );

  assign gsel = grant[REQ_D];

  // Round index and last flag are computed one cycle early so every
  // datapath control output comes straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q   <= S_IDLE;
      r_q     <= 4'd0;
      state_q <= '0;
      dout_q  <= '0;
      mode_q  <= MODE_ENC;
      owner_q <= REQ_E;
      last_q  <= REQ_D;
      ackE_q  <= 1'b0;
      ackD_q  <= 1'b0;
      doneE_q <= 1'b0;
      doneD_q <= 1'b0;
      busy_q  <= 1'b0;
      first_q <= 1'b0;
      lastr_q <= 1'b0;
      round_q <= 4'd0;
    end else begin
      ackE_q  <= 1'b0;
      ackD_q  <= 1'b0;
      doneE_q <= 1'b0;
      doneD_q <= 1'b0;
      unique case (fsm_q)
        S_IDLE: begin
          if (grant != 2'b00) begin
            fsm_q   <= S_LOAD;
            state_q <= gsel ? msgD : msgE;
            mode_q  <= gsel ? MODE_DEC : MODE_ENC;
            owner_q <= gsel;
            ackE_q  <= grant[REQ_E];
            ackD_q  <= grant[REQ_D];
            first_q <= 1'b1;
            lastr_q <= 1'b0;
            round_q <= gsel ? NR4 : 4'd0;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          fsm_q   <= S_ROUND;
          state_q <= dpResult;
          r_q     <= 4'd1;
          first_q <= 1'b0;
          lastr_q <= (NR4 == 4'd1);
          round_q <= mode_q ? NR4 - 4'd1 : 4'd1;
        end
        S_ROUND: begin
          state_q <= dpResult;
          if (r_q == NR4) begin
            fsm_q   <= S_DONE;
            dout_q  <= dpResult;
            doneE_q <= (owner_q == REQ_E);
            doneD_q <= (owner_q == REQ_D);
            lastr_q <= 1'b0;
            round_q <= 4'd0;
          end else begin
            r_q     <= r_q + 4'd1;
            lastr_q <= (r_q + 4'd1 == NR4);
            round_q <= mode_q ? NR4 - r_q - 4'd1
                              : r_q + 4'd1;
          end
        end
        S_DONE: begin
          fsm_q  <= S_IDLE;
          last_q <= owner_q;
          busy_q <= 1'b0;
          r_q    <= 4'd0;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign ackE      = ackE_q;
  assign ackD      = ackD_q;
  assign doneE     = doneE_q;
  assign doneD     = doneD_q;
  assign busy      = busy_q;
  assign dpStateIn = state_q;
  assign dpMode    = mode_q;
  assign dpRound   = round_q;
  assign dpFirst   = first_q;
  assign dpLast    = lastr_q;
  assign dataOut   = dout_q;

endmodule
